// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader slice.
//
// Contents:
//   - boot_state_e : loader FSM encoding (HDR, LOAD, CSUM, RUN, ERR)
//   - header field positions and a helper that builds the reserved-bit mask
//   - default memory address width and GO command word
//   - memory select constants SEL_INSN / SEL_DATA
//
// Optional feature macro used by the files importing this package:
//   BOOT_LOADER_CHECKSUM_EN
package boot_pkg;

  localparam int          BOOT_ADDR_W  = 10;
  localparam logic [31:0] BOOT_GO_WORD = 32'hFFFF_FFFF;

  // Header word layout: [31] sel, [16 +: ADDR_W] base, [0 +: ADDR_W] count-1
  localparam int HDR_SEL_BIT  = 31;
  localparam int HDR_BASE_LSB = 16;
  localparam int HDR_CNT_LSB  = 0;

  localparam logic SEL_INSN = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    LOAD = 3'd1,
    CSUM = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } boot_state_e;

  // Every header bit not belonging to a defined field is reserved.
  // For a 10-bit address this yields 32'h7C00_FC00.
  function automatic logic [31:0] hdr_rsvd_mask(input int aw);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    m[HDR_SEL_BIT] = 1'b0;
    for (int i = 0; i < aw; i++) begin
      m[HDR_BASE_LSB + i] = 1'b0;
      m[HDR_CNT_LSB + i]  = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/boot_csum_acc.sv
// XOR accumulator for block checksums.
//
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   clr        : zero the accumulator (start of a new block)
//   en         : fold din into the accumulator
//   din        : payload word
//   cmp        : word to compare against the running XOR
//   match      : accumulator equals cmp
//
// Only instantiated when BOOT_LOADER_CHECKSUM_EN is defined.
module boot_csum_acc (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  input  logic [31:0] cmp,
  output logic        match
);

  logic [31:0] acc_q;
  logic [31:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 32'h0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= 32'h0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match = (acc_q == cmp);

endmodule

// File: rtl/boot_loader.sv
// Boot loader: turns a 32-bit valid/ready word stream into writes to the
// core's instruction or data memory, holding the core in reset until a GO
// command arrives.
//
// Ports:
//   clk, reset   : clock and asynchronous active-low reset
//   s_valid/s_ready/s_data : input word stream
//   mem_we, mem_sel, mem_addr, mem_wdata : registered memory write port
//                  (mem_sel 0 = instruction memory, 1 = data memory)
//   core_rst_n   : active-low core reset, released after GO
//   busy         : a block payload is in progress
//   err          : sticky error (bad header or checksum mismatch)
//
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN. When defined, each block
// payload is followed by an XOR checksum word checked in the CSUM state.
module boot_loader
  import boot_pkg::*;
#(
  parameter int          ADDR_W  = BOOT_ADDR_W,
  parameter logic [31:0] GO_WORD = BOOT_GO_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              err
);

  localparam logic [31:0]   RSVD_MASK = hdr_rsvd_mask(ADDR_W);
  localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(1) << ADDR_W;

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              sel_q, sel_d;

  logic              s_ready_q, s_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              beat;
  logic [ADDR_W-1:0] hdr_base;
  logic [ADDR_W-1:0] hdr_cnt_m1;
  logic [ADDR_W+1:0] hdr_end;
  logic              hdr_bad;

  assign beat       = s_valid && s_ready_q;
  assign hdr_base   = s_data[HDR_BASE_LSB +: ADDR_W];
  assign hdr_cnt_m1 = s_data[HDR_CNT_LSB +: ADDR_W];
  // One past the last address of the block; widened so it cannot wrap.
  assign hdr_end    = {2'b00, hdr_base} + {2'b00, hdr_cnt_m1} + (ADDR_W+2)'(1);
  assign hdr_bad    = ((s_data & RSVD_MASK) != 32'h0) || (hdr_end > DEPTH);

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic csum_clr;
  logic csum_en;
  logic csum_match;

  boot_csum_acc u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (csum_clr),
    .en    (csum_en),
    .din   (s_data),
    .cmp   (s_data),
    .match (csum_match)
  );
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    csum_clr    = 1'b0;
    csum_en     = 1'b0;
`endif

    case (state_q)
      HDR: begin
        if (beat) begin
          // GO has reserved bits set, so it must be recognised first.
          if (s_data == GO_WORD) begin
            state_d = RUN;
          end else if (hdr_bad) begin
            state_d = ERR;
          end else begin
            sel_d   = s_data[HDR_SEL_BIT];
            base_d  = hdr_base;
            cnt_d   = hdr_cnt_m1;
            idx_d   = '0;
            state_d = LOAD;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_clr = 1'b1;
`endif
          end
        end
      end
      LOAD: begin
        if (beat) begin
          mem_we_d    = 1'b1;
          mem_sel_d   = sel_q;
          mem_addr_d  = base_q + idx_q;
          mem_wdata_d = s_data;
          idx_d       = idx_q + 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum_en     = 1'b1;
`endif
          if (idx_q == cnt_q) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = HDR;
`endif
          end
        end
      end
      CSUM: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (beat) begin
          state_d = csum_match ? HDR : ERR;
        end
`endif
      end
      RUN: begin
        state_d = RUN;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = ERR;
      end
    endcase

    // Status outputs are registered copies of the next-state decode.
    s_ready_d    = (state_d == HDR) || (state_d == LOAD) || (state_d == CSUM);
    busy_d       = (state_d == LOAD);
    err_d        = (state_d == ERR);
    core_rst_n_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HDR;
      base_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      sel_q        <= SEL_INSN;
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= SEL_INSN;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      s_ready_q    <= s_ready_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_sel    = mem_sel_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader. Inputs change on the falling
// edge and outputs are observed on the following falling edge, so every
// registered write is seen exactly one rising edge after its handshake.
module tb_boot_loader;
  import boot_pkg::*;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        mem_we;
  logic        mem_sel;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        err;

  int vectors;
  int miscompares;

  boot_loader dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input cycle and move to the next falling edge.
  task automatic step(input logic v, input logic [31:0] d);
    s_valid = v;
    s_data  = d;
    @(negedge clk);
  endtask

  // Pulse reset and wait (bounded) for the loader to become ready.
  task automatic do_reset();
    int n;
    s_valid = 1'b0;
    s_data  = 32'h0;
    reset   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 10);
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset: s_ready=%b required 1 within 10 cycles", s_ready);
    end
  endtask

  // Check one registered payload write.
  task automatic expect_write(input string name, input logic [9:0] a,
                              input logic [31:0] d, input logic sel);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d || mem_sel !== sel) begin
      miscompares++;
      $display("[TB] FAIL %s: we=%b addr=%0d data=%h sel=%b required we=1 addr=%0d data=%h sel=%b",
               name, mem_we, mem_addr, mem_wdata, mem_sel, a, d, sel);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'h0;
    @(negedge clk);
    vectors++;
    if ({s_ready, mem_we, mem_sel, core_rst_n, busy, err} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: rdy/we/sel/rstn/busy/err=%b required 000000",
               {s_ready, mem_we, mem_sel, core_rst_n, busy, err});
    end
    vectors++;
    if (mem_addr !== 10'd0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: addr=%0d data=%h required 0/0", mem_addr, mem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1 || core_rst_n !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset: s_ready=%b core_rst_n=%b required 1/0", s_ready, core_rst_n);
    end
  endtask

  task automatic test_insn_block();
    logic [31:0] w [3];
    w[0] = 32'hDEAD_BEEF;
    w[1] = 32'h1234_5678;
    w[2] = 32'hCAFE_F00D;
    step(1'b1, 32'h0000_0002);
    vectors++;
    if (mem_we !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL insn_hdr: mem_we=%b busy=%b required 0/1", mem_we, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, w[i]);
      expect_write("insn_write", 10'(i), w[i], SEL_INSN);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL insn_busy_fall: busy=%b required 0", busy);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    step(1'b1, w[0] ^ w[1] ^ w[2]);
`else
    step(1'b0, 32'h0);
`endif
    vectors++;
    if (mem_we !== 1'b0 || err !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL insn_idle: we=%b err=%b rdy=%b required 0/0/1", mem_we, err, s_ready);
    end
  endtask

  task automatic test_data_block_go();
    step(1'b1, 32'h80C8_0001);
    step(1'b1, 32'h0000_0001);
    expect_write("data_write0", 10'd200, 32'h0000_0001, SEL_DATA);
    step(1'b1, 32'h0000_0000);
    expect_write("data_write1", 10'd201, 32'h0000_0000, SEL_DATA);
`ifdef BOOT_LOADER_CHECKSUM_EN
    step(1'b1, 32'h0000_0001);
`endif
    vectors++;
    if (core_rst_n !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pre_go: core_rst_n=%b required 0", core_rst_n);
    end
    step(1'b1, 32'hFFFF_FFFF);
    vectors++;
    if (core_rst_n !== 1'b1 || s_ready !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL go: rstn=%b rdy=%b we=%b required 1/0/0", core_rst_n, s_ready, mem_we);
    end
    step(1'b1, 32'h0000_0000);
    step(1'b1, 32'h1111_1111);
    vectors++;
    if (core_rst_n !== 1'b1 || mem_we !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL run_ignore: rstn=%b we=%b err=%b required 1/0/0", core_rst_n, mem_we, err);
    end
    step(1'b0, 32'h0);
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b1, 32'h0005_0002);
    step(1'b1, 32'hAAAA_0000);
    expect_write("stall_w0", 10'd5, 32'hAAAA_0000, SEL_INSN);
    step(1'b0, 32'hBBBB_BBBB);
    vectors++;
    if (mem_we !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_gap1: we=%b busy=%b required 0/1", mem_we, busy);
    end
    step(1'b0, 32'hBBBB_BBBB);
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_gap2: we=%b required 0", mem_we);
    end
    step(1'b1, 32'hAAAA_0001);
    expect_write("stall_w1", 10'd6, 32'hAAAA_0001, SEL_INSN);
    step(1'b1, 32'hAAAA_0002);
    expect_write("stall_w2", 10'd7, 32'hAAAA_0002, SEL_INSN);
`ifdef BOOT_LOADER_CHECKSUM_EN
    step(1'b1, 32'hAAAA_0003);
`else
    step(1'b0, 32'h0);
`endif
    vectors++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_end: busy=%b we=%b err=%b required 0/0/0", busy, mem_we, err);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    step(1'b1, 32'h03FC_0003);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hA000_0000 + 32'(i));
      expect_write("boundary_write", 10'(1020 + i), 32'hA000_0000 + 32'(i), SEL_INSN);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    step(1'b1, 32'h0000_0000);
`else
    step(1'b0, 32'h0);
`endif
    vectors++;
    if (err !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL boundary_ok: err=%b rdy=%b required 0/1", err, s_ready);
    end
  endtask

  task automatic test_range_error();
    do_reset();
    step(1'b1, 32'h03FC_0004);
    vectors++;
    if (err !== 1'b1 || s_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL range_err: err=%b rdy=%b we=%b busy=%b required 1/0/0/0",
               err, s_ready, mem_we, busy);
    end
    step(1'b1, 32'hFFFF_FFFF);
    step(1'b0, 32'h0);
    vectors++;
    if (core_rst_n !== 1'b0 || err !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL range_go: rstn=%b err=%b we=%b required 0/1/0", core_rst_n, err, mem_we);
    end
    do_reset();
    step(1'b1, 32'h0000_0400);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rsvd_err: err=%b required 1", err);
    end
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    step(1'b1, 32'h0010_0003);
    step(1'b1, 32'h0000_00A0);
    expect_write("mid_w0", 10'd16, 32'h0000_00A0, SEL_INSN);
    step(1'b1, 32'h0000_00A1);
    expect_write("mid_w1", 10'd17, 32'h0000_00A1, SEL_INSN);
    s_valid = 1'b0;
    reset   = 1'b0;
    #1;
    vectors++;
    if ({s_ready, mem_we, mem_sel, core_rst_n, busy, err} !== 6'b0 ||
        mem_addr !== 10'd0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: flags=%b addr=%0d data=%h required 000000/0/0",
               {s_ready, mem_we, mem_sel, core_rst_n, busy, err}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    step(1'b1, 32'h0020_0000);
    step(1'b1, 32'h5555_AAAA);
    expect_write("mid_restart", 10'd32, 32'h5555_AAAA, SEL_INSN);
`ifdef BOOT_LOADER_CHECKSUM_EN
    step(1'b1, 32'h5555_AAAA);
`else
    step(1'b0, 32'h0);
`endif
    vectors++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_restart_end: busy=%b err=%b required 0/0", busy, err);
    end
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    step(1'b1, 32'h0000_0001);
    step(1'b1, 32'h0000_0001);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'h0000_0003);
    vectors++;
    if (err !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL csum_good: err=%b rdy=%b required 0/1", err, s_ready);
    end
    step(1'b1, 32'h0000_0001);
    step(1'b1, 32'h0000_0001);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'h0000_0004);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL csum_bad: err=%b required 1", err);
    end
    step(1'b1, 32'hFFFF_FFFF);
    step(1'b0, 32'h0);
    vectors++;
    if (core_rst_n !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL csum_go: core_rst_n=%b required 0", core_rst_n);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_insn_block();
    test_data_block_go();
    test_stall();
    test_boundary();
    test_range_error();
    test_reset_mid_block();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits directly upstream of the RV32I core top and its instruction/data memories.
- Accepts a 32-bit valid/ready word stream, for example from a UART bridge or a bench driver, and writes block payloads into instruction or data memory.
- Holds the core in reset while loading, then releases it on a GO command.
- Replaces hierarchical memory pokes for program images (e.g. Keccak code, padded state, round constants).

Parameters:
- ADDR_W, 10, word-address width of each memory; DEPTH = 2**ADDR_W words (1024).
- GO_WORD, 32'hFFFF_FFFF, header value that ends loading and releases the core.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- s_valid  input  1  stream word valid.
- s_ready  output  1  loader can accept a word.
- s_data  input  32  stream word.
- mem_we  output  1  write strobe, one cycle per payload word.
- mem_sel  output  1  0 = instruction memory, 1 = data memory.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  write data.
- core_rst_n  output  1  active-low reset to the core; low until GO.
- busy  output  1  a block payload is in progress.
- err  output  1  sticky error flag.

Behaviour:
- Reset values: s_ready=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, core_rst_n=0, busy=0, err=0, state=HDR.
- s_ready=1 in HDR, LOAD and CSUM only. A beat transfers when s_valid and s_ready are both high; s_valid without s_ready is held by the source.
- Header word fields:
  - [31] = sel.
  - [25:16] = base (low ADDR_W bits).
  - [9:0] = count-1.
  - All other bits are reserved and must be 0.
- HDR:
  - Beat == GO_WORD -> RUN.
  - Reserved bit set, or base + count > DEPTH -> ERR.
  - Otherwise latch sel/base/count -> LOAD, busy=1.
- LOAD:
  - Each beat registers mem_we=1, mem_addr=base+i, mem_wdata=s_data, mem_sel=sel, visible the cycle after the handshake (latency 1).
  - mem_we=0 in all other cycles.
  - After the last beat (i = count-1): go to CSUM if CHECKSUM_EN, otherwise HDR; busy clears on that transition.
- Addresses never wrap; range is checked at header time, so the block ending exactly at DEPTH-1 is legal.
- RUN:
  - core_rst_n=1 from the cycle after the GO handshake.
  - s_ready=0; stays in RUN until reset. Further stream words are ignored.
- ERR:
  - s_ready=0, core_rst_n=0, err=1, no writes; stays in ERR until reset.
- Back-to-back beats are accepted every cycle with no bubbles. A gap in s_valid simply stalls the word index.
- Reset mid-block: the block is abandoned immediately, all outputs return to reset values, and memory contents already written are left untouched.
- count field 0 means 1 word; the maximum is 1024 words.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - Each block's payload is followed by one checksum word, consumed in CSUM, equal to the XOR of all payload words.
  - Match -> HDR.
  - Mismatch -> ERR; the payload is already written, err=1 and the core stays in reset.
- Undefined: no CSUM state; the word after the last payload is taken as the next header.

Decomposition:
- Shared package boot_pkg holds:
  - state encoding: HDR, LOAD, CSUM, RUN, ERR;
  - header field positions and the reserved-bit mask;
  - the GO_WORD default;
  - the memory select constants SEL_INSN=0 and SEL_DATA=1.
- One sub-module is natural: boot_csum_acc, an XOR accumulator with clear/enable/compare, instantiated only under BOOT_LOADER_CHECKSUM_EN.

Test Plan:
- Instruction block: header 32'h0000_0002 then words A,B,C, one per cycle -> three mem_we pulses at addresses 0,1,2 with sel=0 and data A,B,C, each one cycle after its handshake; busy falls after C.
- Data block at an offset: header 32'h80C8_0001 (base 200, 2 words) then 32'h0000_0001, 32'h0000_0000 -> writes at addresses 200,201 with sel=1; then GO -> core_rst_n=1 one cycle later and s_ready=0.
- Stalled source: s_valid toggles 1,0,0,1 during LOAD -> no mem_we in the gap cycles, addresses stay contiguous, no duplicate write.
- Range error: header base 1020, count-1=4 (5 words) -> ERR, err=1, no mem_we, core_rst_n stays 0 after a following GO.
- Reset mid-block: assert reset after the 2nd of 4 payload words -> all outputs at reset values. A new header afterwards restarts cleanly at its own base.
- BOOT_LOADER_CHECKSUM_EN checksums:
  - Correct case: words 32'h1, 32'h2, checksum 32'h3 -> returns to HDR, err=0.
  - Wrong case: checksum 32'h4 -> err=1 and GO is ignored.
